rv_fetch_req: RTL and testbench

- Instruction-fetch request stage directly upstream of the fetch buffer.
- Generates word-aligned reads on the instruction bus and tracks outstanding requests.
- Holds returned words in a small skid queue and pushes them into the fetch buffer only when it reports not-full.
- On redirect (branch/trap) it restarts the buffer at the target PC and discards in-flight stale responses.

---
 rtl/rv_fetch_pkg.sv | 15 +
 rtl/rv_fetch_skid.sv | 55 +++++
 rtl/rv_fetch_req.sv | 108 ++++++++++
 tb/tb_rv_fetch_req.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/rv_fetch_pkg.sv
// Shared types and helpers for the instruction-fetch request stage.
package rv_fetch_pkg;

  localparam int IADDR_SPACE_BITS_DEF = 16;

  // Halfword PC and word bus address for the default address space.
  typedef logic [IADDR_SPACE_BITS_DEF-1:1] fetch_pc_t;
  typedef logic [IADDR_SPACE_BITS_DEF-1:2] fetch_waddr_t;

  // Counter width able to hold 0..max_out inclusive.
  function automatic int cnt_width(input int max_out);
    return (max_out < 1) ? 1 : $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/rv_fetch_skid.sv
// Small in-order skid FIFO holding returned instruction words until the
// fetch buffer can take them. Clear has priority over push/pop.
module rv_fetch_skid
  import rv_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = cnt_width(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_clear,
  input  logic [31:0]   i_data,
  output logic [31:0]   o_data,
  output logic [CW-1:0] o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Storage write; contents need no reset, count qualifies them.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/rv_fetch_req.sv
// Instruction-fetch request stage: issues word reads, tracks outstanding
// requests, discards stale responses after a redirect and feeds the fetch
// buffer through a skid queue.
module rv_fetch_req
  import rv_fetch_pkg::*;
#(
  parameter int                          IADDR_SPACE_BITS = 16,
  parameter int                          MAX_OUTSTANDING  = 2,
  parameter logic [IADDR_SPACE_BITS-1:1] RESET_PC         = '0
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_flush,
  input  logic [IADDR_SPACE_BITS-1:1]   i_flush_pc,
  output logic                          o_instr_req,
  output logic [IADDR_SPACE_BITS-1:2]   o_instr_addr,
  input  logic                          i_instr_ack,
  input  logic [31:0]                   i_instr_data,
  input  logic                          i_instr_valid,
  output logic                          o_buf_reset_n,
  output logic [IADDR_SPACE_BITS-1:1]   o_buf_pc,
  output logic [31:0]                   o_buf_data,
  output logic                          o_buf_push,
  input  logic                          i_buf_not_full
);

  localparam int CW = cnt_width(MAX_OUTSTANDING);

  logic                        r_run;
  logic [IADDR_SPACE_BITS-1:1] r_buf_pc;
  logic [IADDR_SPACE_BITS-1:2] r_faddr;
  logic [CW-1:0]               r_out_cnt;
  logic [CW-1:0]               r_drop_cnt;

  logic [CW-1:0] w_skid_cnt;
  logic [31:0]   w_skid_data;
  logic [CW:0]   w_sum;
  logic          w_fire;
  logic          w_rsp;
  logic          w_drop;
  logic          w_skid_wr;

  // Requests in flight plus held words never exceed the skid depth, so the
  // skid cannot overflow. The sum never rises without an ack, which keeps a
  // raised request stable until it is taken.
  assign w_sum       = {1'b0, r_out_cnt} + {1'b0, w_skid_cnt};
  assign o_instr_req = r_run & ~i_flush & (w_sum < (CW+1)'(MAX_OUTSTANDING));
  assign o_instr_addr = r_faddr;
  assign w_fire      = o_instr_req & i_instr_ack;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_rsp     = i_instr_valid & (r_out_cnt != '0);
  assign w_drop    = w_rsp & (r_drop_cnt != '0);
  assign w_skid_wr = w_rsp & ~w_drop & ~i_flush;

  assign o_buf_reset_n = r_run & ~i_flush;
  assign o_buf_pc      = i_flush ? i_flush_pc : r_buf_pc;
  assign o_buf_push    = (w_skid_cnt != '0) & i_buf_not_full & o_buf_reset_n;
  assign o_buf_data    = w_skid_data;

  // Buffer held in restart for the first edge after reset release.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_run <= 1'b0;
    else            r_run <= 1'b1;
  end

  // PC presented to the buffer while it is in restart.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)   r_buf_pc <= RESET_PC;
    else if (i_flush) r_buf_pc <= i_flush_pc;
  end

  // Fetch word address: redirect target, else advance on accepted request.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)   r_faddr <= RESET_PC[IADDR_SPACE_BITS-1:2];
    else if (i_flush) r_faddr <= i_flush_pc[IADDR_SPACE_BITS-1:2];
    else if (w_fire)  r_faddr <= r_faddr + 1'b1;
  end

  // Outstanding count: acked minus returned.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_out_cnt <= '0;
    else            r_out_cnt <= r_out_cnt + CW'(w_fire) - CW'(w_rsp);
  end

  // Stale responses to discard: everything still in flight at a redirect,
  // minus one returning in the redirect cycle itself.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)   r_drop_cnt <= '0;
    else if (i_flush) r_drop_cnt <= r_out_cnt - CW'(w_rsp);
    else if (w_drop)  r_drop_cnt <= r_drop_cnt - CW'(1);
  end

  rv_fetch_skid #(
    .DEPTH (MAX_OUTSTANDING),
    .CW    (CW)
  ) u_skid (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_push    (w_skid_wr),
    .i_pop     (o_buf_push),
    .i_clear   (i_flush),
    .i_data    (i_instr_data),
    .o_data    (w_skid_data),
    .o_count   (w_skid_cnt)
  );

endmodule

// File: tb/tb_rv_fetch_req.sv
// Directed cycle-by-cycle bench for rv_fetch_req: the bus and buffer are
// driven by hand from a vector table plus a few hand-written sequences.
module tb_rv_fetch_req;
  import rv_fetch_pkg::*;

  localparam logic T = 1'b1;
  localparam logic F = 1'b0;
  localparam logic [31:0] Z = 32'h0;
  localparam fetch_pc_t P0 = 15'h0;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  fetch_pc_t    fpc = '0;
  logic         req;
  fetch_waddr_t addr;
  logic         ack = 1'b0;
  logic [31:0]  idata = '0;
  logic         ivld = 1'b0;
  logic         brst;
  fetch_pc_t    bpc;
  logic [31:0]  bdata;
  logic         push;
  logic         nf = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv_fetch_req #(
    .IADDR_SPACE_BITS (16),
    .MAX_OUTSTANDING  (2),
    .RESET_PC         (15'h0)
  ) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_flush        (flush),
    .i_flush_pc     (fpc),
    .o_instr_req    (req),
    .o_instr_addr   (addr),
    .i_instr_ack    (ack),
    .i_instr_data   (idata),
    .i_instr_valid  (ivld),
    .o_buf_reset_n  (brst),
    .o_buf_pc       (bpc),
    .o_buf_data     (bdata),
    .o_buf_push     (push),
    .i_buf_not_full (nf)
  );

  typedef struct {
    logic         fl;
    fetch_pc_t    fpc;
    logic         ack;
    logic         vld;
    logic [31:0]  dat;
    logic         nf;
    logic         e_req;
    fetch_waddr_t e_addr;
    logic         e_brst;
    fetch_pc_t    e_bpc;
    logic         e_push;
    logic [31:0]  e_bdata;
  } vec_t;

  vec_t tbl [29];

  function automatic logic [31:0] memw(input fetch_waddr_t a);
    return {16'hC0DE, 2'b00, a};
  endfunction

  function automatic vec_t v(input logic fl, input fetch_pc_t fp, input logic ak,
                             input logic vl, input logic [31:0] dt, input logic n,
                             input logic er, input fetch_waddr_t ea, input logic eb,
                             input fetch_pc_t ep, input logic eh, input logic [31:0] ed);
    vec_t r;
    r.fl = fl; r.fpc = fp; r.ack = ak; r.vld = vl; r.dat = dt; r.nf = n;
    r.e_req = er; r.e_addr = ea; r.e_brst = eb; r.e_bpc = ep;
    r.e_push = eh; r.e_bdata = ed;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, check outputs 1ns later.
  task automatic apply(input string tag, input vec_t t);
    @(negedge clk);
    flush = t.fl; fpc = t.fpc; ack = t.ack; ivld = t.vld; idata = t.dat; nf = t.nf;
    #1;
    chk({tag, ".req"},   32'(req),  32'(t.e_req));
    chk({tag, ".addr"},  32'(addr), 32'(t.e_addr));
    chk({tag, ".brst"},  32'(brst), 32'(t.e_brst));
    chk({tag, ".bpc"},   32'(bpc),  32'(t.e_bpc));
    chk({tag, ".push"},  32'(push), 32'(t.e_push));
    if (t.e_push) chk({tag, ".bdata"}, bdata, t.e_bdata);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".req"},  32'(req),  32'h0);
    chk({tag, ".addr"}, 32'(addr), 32'h0);
    chk({tag, ".brst"}, 32'(brst), 32'h0);
    chk({tag, ".bpc"},  32'(bpc),  32'h0);
    chk({tag, ".push"}, 32'(push), 32'h0);
  endtask

  initial begin
    //            fl fpc        ak vl dat               nf | req addr     brst bpc        push data
    tbl[0]  = v(F, P0,        T, F, Z,              T,  F, 14'h0,   F, P0,        F, Z);
    tbl[1]  = v(F, P0,        T, F, Z,              T,  T, 14'h0,   T, P0,        F, Z);
    tbl[2]  = v(F, P0,        T, T, memw(14'h0),    T,  T, 14'h1,   T, P0,        F, Z);
    tbl[3]  = v(F, P0,        T, T, memw(14'h1),    T,  F, 14'h2,   T, P0,        T, memw(14'h0));
    tbl[4]  = v(F, P0,        T, F, Z,              T,  T, 14'h2,   T, P0,        T, memw(14'h1));
    tbl[5]  = v(F, P0,        T, T, memw(14'h2),    T,  T, 14'h3,   T, P0,        F, Z);
    // buffer stalls: skid fills with 2 words, issue stops
    tbl[6]  = v(F, P0,        T, T, memw(14'h3),    F,  F, 14'h4,   T, P0,        F, Z);
    tbl[7]  = v(F, P0,        T, F, Z,              F,  F, 14'h4,   T, P0,        F, Z);
    tbl[8]  = v(F, P0,        T, F, Z,              F,  F, 14'h4,   T, P0,        F, Z);
    tbl[9]  = v(F, P0,        T, F, Z,              F,  F, 14'h4,   T, P0,        F, Z);
    // release: two consecutive pushes, then issue resumes
    tbl[10] = v(F, P0,        T, F, Z,              T,  F, 14'h4,   T, P0,        T, memw(14'h2));
    tbl[11] = v(F, P0,        F, F, Z,              T,  T, 14'h4,   T, P0,        T, memw(14'h3));
    tbl[12] = v(F, P0,        F, F, Z,              T,  T, 14'h4,   T, P0,        F, Z);
    tbl[13] = v(F, P0,        T, F, Z,              T,  T, 14'h4,   T, P0,        F, Z);
    tbl[14] = v(F, P0,        T, F, Z,              T,  T, 14'h5,   T, P0,        F, Z);
    // redirect to 0x0042 with 2 outstanding, no response in flush cycle
    tbl[15] = v(T, 15'h0042,  T, F, Z,              T,  F, 14'h6,   F, 15'h0042,  F, Z);
    tbl[16] = v(F, P0,        T, T, 32'hDEAD0004,   T,  F, 14'h21,  T, 15'h0042,  F, Z);
    tbl[17] = v(F, P0,        T, T, 32'hDEAD0005,   T,  T, 14'h21,  T, 15'h0042,  F, Z);
    tbl[18] = v(F, P0,        T, T, memw(14'h21),   T,  T, 14'h22,  T, 15'h0042,  F, Z);
    tbl[19] = v(F, P0,        F, F, Z,              T,  F, 14'h23,  T, 15'h0042,  T, memw(14'h21));
    // redirect coinciding with a response: that response is discarded
    tbl[20] = v(T, 15'h0100,  T, T, memw(14'h22),   T,  F, 14'h23,  F, 15'h0100,  F, Z);
    tbl[21] = v(F, P0,        T, F, Z,              T,  T, 14'h80,  T, 15'h0100,  F, Z);
    tbl[22] = v(F, P0,        F, T, memw(14'h80),   T,  T, 14'h81,  T, 15'h0100,  F, Z);
    tbl[23] = v(F, P0,        F, F, Z,              T,  T, 14'h81,  T, 15'h0100,  T, memw(14'h80));
    // response with nothing outstanding is ignored
    tbl[24] = v(F, P0,        F, T, 32'hBAD0BAD0,   T,  T, 14'h81,  T, 15'h0100,  F, Z);
    tbl[25] = v(F, P0,        F, F, Z,              T,  T, 14'h81,  T, 15'h0100,  F, Z);
    // top-of-space word address wraps to zero
    tbl[26] = v(T, 15'h7FFE,  F, F, Z,              T,  F, 14'h81,  F, 15'h7FFE,  F, Z);
    tbl[27] = v(F, P0,        T, F, Z,              T,  T, 14'h3FFF, T, 15'h7FFE, F, Z);
    tbl[28] = v(F, P0,        F, F, Z,              T,  T, 14'h0,   T, 15'h7FFE,  F, Z);

    // reset state while held in reset
    @(negedge clk);
    #1;
    chk_reset_outputs("rst");
    @(posedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 29; i++) apply($sformatf("vec%0d", i), tbl[i]);

    // Async reset with a full skid: outputs drop without a clock edge.
    apply("A1", v(F, P0, T, T, memw(14'h3FFF), F,  T, 14'h0, T, 15'h7FFE, F, Z));
    apply("A2", v(F, P0, T, T, memw(14'h0),    F,  F, 14'h1, T, 15'h7FFE, F, Z));
    apply("A3", v(F, P0, F, F, Z,              T,  F, 14'h1, T, 15'h7FFE, T, memw(14'h3FFF)));
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    @(posedge clk);
    #2 rst_n = 1'b1;
    apply("R0", v(F, P0, F, F, Z, T,  F, 14'h0, F, P0, F, Z));
    apply("R1", v(F, P0, F, F, Z, T,  T, 14'h0, T, P0, F, Z));
    apply("R2", v(F, P0, F, F, Z, T,  T, 14'h0, T, P0, F, Z));

    // Back-to-back redirects two cycles apart: only target-2 data is pushed.
    apply("B1", v(F, P0,       T, F, Z,             T,  T, 14'h0,   T, P0,       F, Z));
    apply("B2", v(F, P0,       T, F, Z,             T,  T, 14'h1,   T, P0,       F, Z));
    apply("B3", v(T, 15'h0200, T, T, memw(14'h0),   T,  F, 14'h2,   F, 15'h0200, F, Z));
    apply("B4", v(F, P0,       T, T, memw(14'h1),   T,  T, 14'h100, T, 15'h0200, F, Z));
    apply("B5", v(T, 15'h0400, T, F, Z,             T,  F, 14'h101, F, 15'h0400, F, Z));
    apply("B6", v(F, P0,       T, T, memw(14'h100), T,  T, 14'h200, T, 15'h0400, F, Z));
    apply("B7", v(F, P0,       F, T, memw(14'h200), T,  T, 14'h201, T, 15'h0400, F, Z));
    apply("B8", v(F, P0,       F, F, Z,             T,  T, 14'h201, T, 15'h0400, T, memw(14'h200)));
    apply("B9", v(F, P0,       F, F, Z,             T,  T, 14'h201, T, 15'h0400, F, Z));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
